// File: rtl/tlp_pkg.sv
// Shared TLP-layer constants: sideband bit offsets above the payload in a packed
// beat, and the drop-counter width.
package tlp_pkg;

    localparam int TLP_SOP_BIT   = 0;
    localparam int TLP_EOP_BIT   = 1;
    localparam int TLP_EMPTY_BIT = 2;
    localparam int TLP_SB_W      = 3;
    localparam int DROP_CNT_W    = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tlp_rp_txfifo_if.sv
// Root-port TX FIFO bus: request-path write side plus the TX-arbiter read side.
// master = producer/consumer environment, slave = the FIFO.
interface tlp_rp_txfifo_if #(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_DEPTH      = 64
);
    import tlp_pkg::*;

    localparam int C_AW = $clog2(C_DEPTH);

    logic [C_DATA_WIDTH-1:0]          RpTxData;
    logic                             RpTxSop;
    logic                             RpTxEop;
    logic                             RpTxEmpty;
    logic                             RpTxValid;
    logic                             RpTxReady;
    logic                             RpTxAbort;
    logic [C_DATA_WIDTH+TLP_SB_W-1:0] TxRpFifoData;
    logic                             TxRpFifoRdReq;
    logic                             RpTLPReady;
    logic [C_AW:0]                    RpFifoLevel;
    logic [DROP_CNT_W-1:0]            RpDropCnt;

    modport master (
        output RpTxData, RpTxSop, RpTxEop, RpTxEmpty, RpTxValid, RpTxAbort, TxRpFifoRdReq,
        input  RpTxReady, TxRpFifoData, RpTLPReady, RpFifoLevel, RpDropCnt
    );

    modport slave (
        input  RpTxData, RpTxSop, RpTxEop, RpTxEmpty, RpTxValid, RpTxAbort, TxRpFifoRdReq,
        output RpTxReady, TxRpFifoData, RpTLPReady, RpFifoLevel, RpDropCnt
    );

endinterface

// File: rtl/tlp_rp_fifo_ram.sv
// Simple dual-port storage: registered write, asynchronous read (distributed RAM).
module tlp_rp_fifo_ram #(
    parameter int W     = 131,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tlp_rp_txfifo.sv
// Store-and-forward root-port TX TLP FIFO; a TLP is readable only once its Eop beat
// is stored. Optional abort/oversize dropping is enabled by TLP_RP_TXFIFO_DROP_EN.
module tlp_rp_txfifo
    import tlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_DEPTH      = 64,
    parameter int C_AW         = $clog2(C_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    tlp_rp_txfifo_if.slave  bus
);

    localparam int W  = C_DATA_WIDTH + TLP_SB_W;
    localparam int PW = C_AW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level;
    logic          full, tlp_ready, wr_acc, wr_store, rd_en;
    logic [W-1:0]  wdata, rdata;

    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = (level == PW'(C_DEPTH));
    assign tlp_ready = (rd_ptr_q != commit_ptr_q);
    assign rd_en     = bus.TxRpFifoRdReq && tlp_ready;
    assign wr_acc    = bus.RpTxValid && bus.RpTxReady;

`ifdef TLP_RP_TXFIFO_DROP_EN
    logic                  dropping_q, dropping_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  abort_eff, oversize;

    assign abort_eff = bus.RpTxAbort && (wr_ptr_q != commit_ptr_q);
    // Full with nothing committed: every stored beat belongs to the open TLP, so it can never fit.
    assign oversize  = full && (rd_ptr_q == commit_ptr_q);

    assign bus.RpTxReady = !full || dropping_q || oversize;
    assign bus.RpDropCnt = drop_cnt_q;
`else
    assign bus.RpTxReady = !full;
    assign bus.RpDropCnt = '0;
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
        wr_store     = wr_acc;
`ifdef TLP_RP_TXFIFO_DROP_EN
        drop_cnt_d   = drop_cnt_q;
        dropping_d   = dropping_q;
        if (abort_eff) begin
            wr_store   = 1'b0;
            wr_ptr_d   = commit_ptr_q;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else if (oversize || dropping_q) begin
            // Swallow beats through the Eop; the beat presented with oversize is already part of the drop.
            wr_store   = 1'b0;
            dropping_d = !(wr_acc && bus.RpTxEop);
            if (oversize) begin
                wr_ptr_d   = commit_ptr_q;
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
        end
`endif
        if (wr_store) begin
            wr_ptr_d = wr_ptr_q + ONE;
            if (bus.RpTxEop) commit_ptr_d = wr_ptr_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
`ifdef TLP_RP_TXFIFO_DROP_EN
            dropping_q   <= 1'b0;
            drop_cnt_q   <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
`ifdef TLP_RP_TXFIFO_DROP_EN
            dropping_q   <= dropping_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    always_comb begin
        wdata                               = '0;
        wdata[C_DATA_WIDTH-1:0]             = bus.RpTxData;
        wdata[C_DATA_WIDTH + TLP_SOP_BIT]   = bus.RpTxSop;
        wdata[C_DATA_WIDTH + TLP_EOP_BIT]   = bus.RpTxEop;
        wdata[C_DATA_WIDTH + TLP_EMPTY_BIT] = bus.RpTxEmpty;
    end

    tlp_rp_fifo_ram #(
        .W     (W),
        .DEPTH (C_DEPTH),
        .AW    (C_AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_store),
        .waddr (wr_ptr_q[C_AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr_q[C_AW-1:0]),
        .rdata (rdata)
    );

    assign bus.TxRpFifoData = tlp_ready ? rdata : '0;
    assign bus.RpTLPReady   = tlp_ready;
    assign bus.RpFifoLevel  = level;

endmodule

// File: tb/tb_tlp_rp_txfifo.sv
// Directed bench for tlp_rp_txfifo: queue-based TLP model compared every cycle,
// plus literal spot checks. Drop tests run when TLP_RP_TXFIFO_DROP_EN is defined.
module tb_tlp_rp_txfifo;

    localparam int DW    = 128;
    localparam int DEPTH = 64;
    typedef logic [DW+2:0] w_t;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    tlp_rp_txfifo_if #(.C_DATA_WIDTH(DW), .C_DEPTH(DEPTH)) bus ();

    tlp_rp_txfifo #(.C_DATA_WIDTH(DW), .C_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: committed beats visible to the reader, beats of the open TLP, drop state.
    w_t          cq[$];
    w_t          oq[$];
    int unsigned m_cnt = 0;
    bit          m_drop = 0;

    function automatic bit m_oversize();
`ifdef TLP_RP_TXFIFO_DROP_EN
        return (cq.size() + oq.size() == DEPTH) && (cq.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        return (cq.size() + oq.size() != DEPTH) || m_drop || m_oversize();
    endfunction

    task automatic model_step();
        bit wr, ovs, abt;
        w_t b;
        if (rst) begin
            cq.delete(); oq.delete(); m_cnt = 0; m_drop = 0;
            return;
        end
        wr  = bus.RpTxValid && m_ready();
        ovs = m_oversize();
        abt = 1'b0;
`ifdef TLP_RP_TXFIFO_DROP_EN
        abt = bus.RpTxAbort && (oq.size() != 0);
`endif
        if (bus.TxRpFifoRdReq && cq.size() != 0) void'(cq.pop_front());
        b = {bus.RpTxEmpty, bus.RpTxEop, bus.RpTxSop, bus.RpTxData};
        if (abt) begin
            oq.delete();
            if (m_cnt != 16'hFFFF) m_cnt++;
        end else if (ovs || m_drop) begin
            if (ovs) begin
                oq.delete();
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
            m_drop = !(wr && bus.RpTxEop);
        end else if (wr) begin
            oq.push_back(b);
            if (bus.RpTxEop) begin
                foreach (oq[i]) cq.push_back(oq[i]);
                oq.delete();
            end
        end
    endtask

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_ready",  w_t'(bus.RpTxReady),   w_t'(m_ready()));
            chk("cyc_tlprdy", w_t'(bus.RpTLPReady),  w_t'(cq.size() != 0));
            chk("cyc_data",   bus.TxRpFifoData,      (cq.size() != 0) ? cq[0] : w_t'(0));
            chk("cyc_level",  w_t'(bus.RpFifoLevel), w_t'(cq.size() + oq.size()));
            chk("cyc_dropcnt", w_t'(bus.RpDropCnt),  w_t'(m_cnt));
        end
    end

    task automatic step(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put(input logic [DW-1:0] d, input bit s, input bit e);
        int tries = 0;
        bus.RpTxData = d; bus.RpTxSop = s; bus.RpTxEop = e; bus.RpTxValid = 1;
        while (!bus.RpTxReady && tries < 200) begin step(1); tries++; end
        if (tries >= 200) begin
            checks++; errors++;
            $display("FAIL put_timeout actual=ready_low required=accept");
        end
        step(1);
        bus.RpTxValid = 0; bus.RpTxSop = 0; bus.RpTxEop = 0;
    endtask

    logic [DW-1:0] a5, d1, d2, d3;

    initial begin
        rst = 1;
        bus.RpTxData = '0; bus.RpTxSop = 0; bus.RpTxEop = 0; bus.RpTxEmpty = 0;
        bus.RpTxValid = 0; bus.RpTxAbort = 0; bus.TxRpFifoRdReq = 0;
        @(posedge clk); #1;
        chk_en = 1;
        step(1);
        rst = 0;
        step(1);

        // Reset state
        chk("rst_ready",  w_t'(bus.RpTxReady),   w_t'(1));
        chk("rst_tlprdy", w_t'(bus.RpTLPReady),  w_t'(0));
        chk("rst_data",   bus.TxRpFifoData,      w_t'(0));
        chk("rst_level",  w_t'(bus.RpFifoLevel), w_t'(0));
        chk("rst_drop",   w_t'(bus.RpDropCnt),   w_t'(0));

        // Single-beat TLP
        a5 = {16{8'hA5}};
        put(a5, 1, 1);
        chk("single_tlprdy", w_t'(bus.RpTLPReady), w_t'(1));
        chk("single_data",   bus.TxRpFifoData,     {3'b011, a5});
        bus.TxRpFifoRdReq = 1; step(1); bus.TxRpFifoRdReq = 0;
        chk("single_popped", w_t'(bus.RpTLPReady), w_t'(0));

        // 3-beat TLP with reader requesting throughout
        d1 = 128'h1111; d2 = 128'h2222; d3 = 128'h3333;
        bus.TxRpFifoRdReq = 1;
        put(d1, 1, 0); chk("tlp3_hidden1", w_t'(bus.RpTLPReady), w_t'(0));
        put(d2, 0, 0); chk("tlp3_hidden2", w_t'(bus.RpTLPReady), w_t'(0));
        put(d3, 0, 1);
        chk("tlp3_b1", bus.TxRpFifoData, {3'b001, d1});
        step(1); chk("tlp3_b2", bus.TxRpFifoData, {3'b000, d2});
        step(1); chk("tlp3_b3", bus.TxRpFifoData, {3'b010, d3});
        step(1); chk("tlp3_done", w_t'(bus.RpTLPReady), w_t'(0));
        bus.TxRpFifoRdReq = 0;

        // Fill to full, then stream pop+write across several pointer wraps
        for (int i = 0; i < DEPTH; i++) put(DW'(i), 1, 1);
        chk("full_level", w_t'(bus.RpFifoLevel), w_t'(64));
        chk("full_ready", w_t'(bus.RpTxReady),   w_t'(0));
        bus.TxRpFifoRdReq = 1; bus.RpTxValid = 1; bus.RpTxSop = 1; bus.RpTxEop = 1;
        for (int k = 0; k < 3 * 2 * DEPTH; k++) begin
            bus.RpTxData = DW'(1000 + k);
            step(1);
        end
        bus.RpTxValid = 0; bus.RpTxSop = 0; bus.RpTxEop = 0;
        chk("stream_level", w_t'(bus.RpFifoLevel), w_t'(63));
        step(DEPTH);
        bus.TxRpFifoRdReq = 0;
        chk("drain_level", w_t'(bus.RpFifoLevel), w_t'(0));

        // Read requests while empty
        bus.TxRpFifoRdReq = 1; step(5);
        chk("empty_level", w_t'(bus.RpFifoLevel), w_t'(0));
        chk("empty_data",  bus.TxRpFifoData,      w_t'(0));
        bus.TxRpFifoRdReq = 0;
        put(128'hBEEF, 1, 1);
        chk("after_empty_data", bus.TxRpFifoData, {3'b011, 128'hBEEF});
        bus.TxRpFifoRdReq = 1; step(1); bus.TxRpFifoRdReq = 0;

        // Reset with one committed beat and four open beats stored
        put(128'hC0, 1, 1);
        put(128'hC1, 1, 0);
        for (int i = 2; i < 5; i++) put(DW'(128'hC0 + i), 0, 0);
        chk("pre_rst_level", w_t'(bus.RpFifoLevel), w_t'(5));
        rst = 1; step(1); rst = 0;
        chk("midrst_level",  w_t'(bus.RpFifoLevel), w_t'(0));
        chk("midrst_tlprdy", w_t'(bus.RpTLPReady),  w_t'(0));
        chk("midrst_ready",  w_t'(bus.RpTxReady),   w_t'(1));
        step(2);

`ifdef TLP_RP_TXFIFO_DROP_EN
        // Abort an open TLP behind a committed one
        put(128'hA1, 1, 0); put(128'hA2, 0, 1);
        put(128'hB1, 1, 0); put(128'hB2, 0, 0);
        chk("abort_pre_level", w_t'(bus.RpFifoLevel), w_t'(4));
        bus.RpTxData = 128'hB3; bus.RpTxValid = 1; bus.RpTxAbort = 1;
        step(1);
        bus.RpTxValid = 0; bus.RpTxAbort = 0;
        chk("abort_level", w_t'(bus.RpFifoLevel), w_t'(2));
        chk("abort_cnt",   w_t'(bus.RpDropCnt),   w_t'(1));
        chk("abort_head",  bus.TxRpFifoData,      {3'b001, 128'hA1});
        bus.RpTxAbort = 1; step(1); bus.RpTxAbort = 0;
        chk("abort_idle_cnt", w_t'(bus.RpDropCnt), w_t'(1));
        bus.TxRpFifoRdReq = 1; step(1);
        chk("abort_tail", bus.TxRpFifoData, {3'b010, 128'hA2});
        step(1); bus.TxRpFifoRdReq = 0;
        chk("abort_empty", w_t'(bus.RpFifoLevel), w_t'(0));

        // Oversize TLP is dropped, the next one passes
        for (int i = 0; i < 70; i++) put(DW'(500 + i), i == 0, i == 69);
        chk("ovs_cnt",   w_t'(bus.RpDropCnt),   w_t'(2));
        chk("ovs_level", w_t'(bus.RpFifoLevel), w_t'(0));
        put(128'hD1, 1, 0); put(128'hD2, 0, 1);
        chk("ovs_next_head", bus.TxRpFifoData, {3'b001, 128'hD1});
        bus.TxRpFifoRdReq = 1; step(2); bus.TxRpFifoRdReq = 0;
        chk("ovs_next_done", w_t'(bus.RpFifoLevel), w_t'(0));
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
